// File: rtl/lsu_ctrl.sv
// Load/store controller between execute and a word-only data memory.
// Sub-word stores are done as read-modify-write; bad accesses return an error without touching memory.
module lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    output logic [31:0] addr_o,
    output logic [31:0] store_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_in_i
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_e;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        funct3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // BU/HU are load-only encodings, so a store using them counts as illegal.
    always_comb begin
        funct3_bad = 1'b0;
        misaligned = 1'b0;
        case (req_funct3_i)
            3'b000: misaligned = 1'b0;
            3'b001: misaligned = req_addr_i[0];
            3'b010: misaligned = |req_addr_i[1:0];
            3'b100: funct3_bad = req_store_i;
            3'b101: begin
                funct3_bad = req_store_i;
                misaligned = req_addr_i[0];
            end
            default: funct3_bad = 1'b1;
        endcase
    end

    assign out_of_range = {1'b0, req_addr_i} >= MEM_BYTES;
    assign req_err      = funct3_bad | misaligned | out_of_range;

    always_comb begin
        lane_b = mem_in_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_in_i[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h000000, lane_b};
            3'b101:  load_ext = {16'h0000, lane_h};
            default: load_ext = mem_in_i;
        endcase
        merged = mem_in_i;
        if (funct3_q == 3'b000) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wbuf_d   = wbuf_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    store_d  = req_store_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i[15:0];
                    wbuf_d   = req_wdata_i;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_store_i && req_funct3_i == 3'b010) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = MERGE;
            MERGE: begin
                if (store_q) begin
                    wbuf_d  = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = RESP;
                end
            end
            WR: state_d = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 16'h0;
            wbuf_q   <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory-side outputs depend only on state and latched fields, never on req_*.
    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = (state_q == RESP) ? rdata_q : 32'h0;
    assign resp_err_o   = (state_q == RESP) ? err_q : 1'b0;
    assign mem_read_o   = (state_q == RD);
    assign mem_write_o  = (state_q == WR);
    assign store_data_o = (state_q == WR) ? wbuf_q : 32'h0;
    assign addr_o       = (state_q == RD || state_q == MERGE || state_q == WR)
                          ? {addr_q[31:2], 2'b00} : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word memory model that registers its read data.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqStore = 1'b0;
    logic [2:0]  reqFunct3 = 3'b000;
    logic [31:0] reqAddr = 32'h0;
    logic [31:0] reqWdata = 32'h0;
    logic        respValid;
    logic        respReady = 1'b1;
    logic [31:0] respData;
    logic        respErr;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memIn;

    logic        preWe = 1'b0;
    logic [31:0] preAddr = 32'h0;
    logic [31:0] preData = 32'h0;
    logic [31:0] mem [0:255];
    logic        overlapSeen = 1'b0;

    int checks = 0;
    int errors = 0;

    int          obsLat;
    int          obsReads;
    int          obsWrites;
    logic [31:0] obsStore;
    logic [31:0] obsData;
    logic        obsErr;
    logic        obsReady1;

    lsu_ctrl #(.MEM_WORDS(256)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_store_i  (reqStore),
        .req_funct3_i (reqFunct3),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_data_o  (respData),
        .resp_err_o   (respErr),
        .addr_o       (addr),
        .store_data_o (storeData),
        .mem_read_o   (memRead),
        .mem_write_o  (memWrite),
        .mem_in_i     (memIn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preWe) begin
            mem[preAddr[9:2]] <= preData;
        end else if (memWrite) begin
            mem[addr[9:2]] <= storeData;
        end
        if (memRead) begin
            memIn <= mem[addr[9:2]];
        end
    end

    always @(negedge clk) begin
        if (memRead && memWrite) begin
            overlapSeen = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preloadWord(input logic [31:0] a, input logic [31:0] d);
        preWe = 1'b1;
        preAddr = a;
        preData = d;
        @(posedge clk);
        #1;
        preWe = 1'b0;
    endtask

    // Called just after a rising edge with the controller idle and resp_ready high.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        reqValid = 1'b1;
        reqStore = st;
        reqFunct3 = f3;
        reqAddr = a;
        reqWdata = wd;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        obsLat = 0;
        obsReads = 0;
        obsWrites = 0;
        obsStore = 32'h0;
        obsData = 32'h0;
        obsErr = 1'b0;
        obsReady1 = 1'b1;
        for (int c = 1; c <= 20 && obsLat == 0; c++) begin
            @(negedge clk);
            if (c == 1) obsReady1 = reqReady;
            if (memRead) obsReads++;
            if (memWrite) begin
                obsWrites++;
                obsStore = storeData;
            end
            if (respValid) begin
                obsLat = c;
                obsData = respData;
                obsErr = respErr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic loadCase(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(1'b0, f3, a, 32'h0);
        checkOutput({tag, "_data"}, obsData, exp);
        checkOutput({tag, "_err"}, 32'(obsErr), 32'h0);
        checkOutput({tag, "_lat"}, obsLat, 32'd3);
    endtask

    task automatic errCase(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a);
        applyStimulus(st, f3, a, 32'hDEAD_BEEF);
        checkOutput({tag, "_err"}, 32'(obsErr), 32'h1);
        checkOutput({tag, "_lat"}, obsLat, 32'd1);
        checkOutput({tag, "_data"}, obsData, 32'h0);
        checkOutput({tag, "_strobes"}, obsReads + obsWrites, 32'd0);
    endtask

    initial begin
        int waited;
        int stableBad;
        int readyBad;
        int strobeBad;
        int accCount;
        int respCount;
        int respBad;
        int accCycles [4];

        #2;
        checkOutput("rst_req_ready", 32'(reqReady), 32'h1);
        checkOutput("rst_resp_valid", 32'(respValid), 32'h0);
        checkOutput("rst_strobes", {30'h0, memRead, memWrite}, 32'h0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_store_data", storeData, 32'h0);
        checkOutput("rst_resp_data", respData, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        preloadWord(32'h40, 32'h8070_F0A5);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0);
        checkOutput("lw_data", obsData, 32'h8070_F0A5);
        checkOutput("lw_err", 32'(obsErr), 32'h0);
        checkOutput("lw_lat", obsLat, 32'd3);
        checkOutput("lw_reads", obsReads, 32'd1);
        checkOutput("lw_writes", obsWrites, 32'd0);
        checkOutput("lw_ready_c1", 32'(obsReady1), 32'h0);
        loadCase("lb41", 3'b000, 32'h41, 32'hFFFF_FFF0);
        loadCase("lbu41", 3'b100, 32'h41, 32'h0000_00F0);
        loadCase("lh42", 3'b001, 32'h42, 32'hFFFF_8070);
        loadCase("lhu42", 3'b101, 32'h42, 32'h0000_8070);
        loadCase("lb40", 3'b000, 32'h40, 32'hFFFF_FFA5);
        loadCase("lbu43", 3'b100, 32'h43, 32'h0000_0080);
        loadCase("lh40", 3'b001, 32'h40, 32'hFFFF_F0A5);

        preloadWord(32'h10, 32'h1122_3344);
        applyStimulus(1'b1, 3'b000, 32'h12, 32'h0000_00AB);
        checkOutput("sb_reads", obsReads, 32'd1);
        checkOutput("sb_writes", obsWrites, 32'd1);
        checkOutput("sb_store", obsStore, 32'h11AB_3344);
        checkOutput("sb_lat", obsLat, 32'd4);
        checkOutput("sb_data", obsData, 32'h0);
        checkOutput("sb_err", 32'(obsErr), 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h10, 32'h1234_BEEF);
        checkOutput("sh_store", obsStore, 32'h11AB_BEEF);
        checkOutput("sh_lat", obsLat, 32'd4);
        loadCase("lw10", 3'b010, 32'h10, 32'h11AB_BEEF);
        applyStimulus(1'b1, 3'b010, 32'h14, 32'h1234_5678);
        checkOutput("sw_lat", obsLat, 32'd2);
        checkOutput("sw_reads", obsReads, 32'd0);
        checkOutput("sw_store", obsStore, 32'h1234_5678);
        loadCase("lw14", 3'b010, 32'h14, 32'h1234_5678);

        errCase("lw42", 1'b0, 3'b010, 32'h42);
        errCase("sh13", 1'b1, 3'b001, 32'h13);
        errCase("lw400", 1'b0, 3'b010, 32'h400);
        errCase("st_f3_100", 1'b1, 3'b100, 32'h10);
        errCase("lh41", 1'b0, 3'b001, 32'h41);
        errCase("ld_f3_011", 1'b0, 3'b011, 32'h40);
        applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0);
        checkOutput("lw3fc_err", 32'(obsErr), 32'h0);
        checkOutput("lw3fc_lat", obsLat, 32'd3);
        loadCase("lw10_after_err", 3'b010, 32'h10, 32'h11AB_BEEF);

        // Hold the response for 10 cycles and confirm nothing moves.
        respReady = 1'b0;
        reqValid = 1'b1;
        reqStore = 1'b0;
        reqFunct3 = 3'b010;
        reqAddr = 32'h40;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        waited = 0;
        while (!respValid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("bp_resp_valid", 32'(respValid), 32'h1);
        stableBad = 0;
        readyBad = 0;
        strobeBad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!respValid || respData !== 32'h8070_F0A5 || respErr !== 1'b0) stableBad++;
            if (reqReady) readyBad++;
            if (memRead || memWrite) strobeBad++;
        end
        checkOutput("bp_stable", stableBad, 32'd0);
        checkOutput("bp_ready_low", readyBad, 32'd0);
        checkOutput("bp_no_strobe", strobeBad, 32'd0);
        @(posedge clk);
        #1;
        respReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_ready_after", 32'(reqReady), 32'h1);
        checkOutput("bp_valid_after", 32'(respValid), 32'h0);

        // Reset arrives while an SB is in its write cycle.
        preloadWord(32'h20, 32'hCAFE_BABE);
        reqValid = 1'b1;
        reqStore = 1'b1;
        reqFunct3 = 3'b000;
        reqAddr = 32'h20;
        reqWdata = 32'h11;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_mid_wr_high", 32'(memWrite), 32'h1);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("rst_mid_wr_drop", 32'(memWrite), 32'h0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_resp_valid", 32'(respValid), 32'h0);
        checkOutput("rst_mid_req_ready", 32'(reqReady), 32'h1);
        @(posedge clk);
        #1;
        loadCase("lw20_after_rst", 3'b010, 32'h20, 32'hCAFE_BABE);

        // Back-to-back loads with resp_ready held high.
        accCount = 0;
        respCount = 0;
        respBad = 0;
        for (int i = 0; i < 4; i++) accCycles[i] = -1;
        reqValid = 1'b1;
        reqStore = 1'b0;
        reqFunct3 = 3'b010;
        reqAddr = 32'h40;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (reqValid && reqReady) begin
                if (accCount < 4) accCycles[accCount] = k;
                accCount++;
            end
            if (respValid) begin
                respCount++;
                if (respData !== 32'h8070_F0A5) respBad++;
            end
            @(posedge clk);
            #1;
            if (k == 12) reqValid = 1'b0;
        end
        checkOutput("b2b_accepts", accCount, 32'd4);
        checkOutput("b2b_acc0", accCycles[0], 32'd0);
        checkOutput("b2b_acc1", accCycles[1], 32'd4);
        checkOutput("b2b_acc2", accCycles[2], 32'd8);
        checkOutput("b2b_acc3", accCycles[3], 32'd12);
        checkOutput("b2b_resps", respCount, 32'd4);
        checkOutput("b2b_resp_data", respBad, 32'd0);
        checkOutput("strobe_overlap", 32'(overlapSeen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
